// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: PIN authentication with lockout, then {sel, amt} handoff via valid/ready.
// Optional idle-timeout abort is built only when ATM_SESSION_TIMEOUT_EN is defined.
module atm_session_ctrl #(
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       card_in,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic [3:0] prefed,
  input  logic       txn_ready,
  output logic [3:0] pin,
  output logic [1:0] sel,
  output logic [3:0] amt,
  output logic       txn_valid,
  output logic       auth_ok,
  output logic [2:0] tries,
  output logic       locked,
  output logic       timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PIN   = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_AMT   = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [3:0] pin_q, pin_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] amt_q, amt_d;
  logic [2:0] tries_q, tries_d;
  logic       txn_valid_q, txn_valid_d;
  logic       auth_ok_q, auth_ok_d;
  logic       locked_q, locked_d;
  logic [2:0] tries_inc;
  logic       in_session;
  logic       timeout_hit;

  assign tries_inc  = tries_q + 3'd1;
  assign in_session = (state_q == S_PIN) || (state_q == S_SEL) ||
                      (state_q == S_AMT) || (state_q == S_ISSUE);

`ifdef ATM_SESSION_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       timeout_q;
  logic       cnt_run;

  assign cnt_run     = (state_q == S_PIN) || (state_q == S_SEL) || (state_q == S_AMT);
  // Card removal and keys both take precedence over an expiring counter.
  assign timeout_hit = cnt_run && card_in && !key_valid && (idle_cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_d = 8'd0;
    if (cnt_run && !key_valid && (state_d == state_q) && (idle_cnt_q != 8'hff)) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    sel_d     = sel_q;
    amt_d     = amt_q;
    tries_d   = tries_q;
    auth_ok_d = auth_ok_q;
    if (in_session && !card_in) begin
      state_d   = S_IDLE;
      auth_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          auth_ok_d = 1'b0;
          if (card_in) state_d = S_PIN;
        end
        S_PIN: begin
          if (key_valid) begin
            pin_d = key_data;
            if (key_data == prefed) begin
              state_d   = S_SEL;
              auth_ok_d = 1'b1;
              tries_d   = 3'd0;
            end else begin
              tries_d = tries_inc;
              if (tries_inc == 3'(MAX_TRIES)) state_d = S_LOCK;
            end
          end
        end
        S_SEL: begin
          if (key_valid && (key_data[3:1] == 3'b000)) begin
            sel_d   = key_data[1:0];
            state_d = S_AMT;
          end
        end
        S_AMT: begin
          if (key_valid) begin
            amt_d   = key_data;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (txn_valid_q && txn_ready) state_d = S_SEL;
        end
        S_LOCK: ;
        default: state_d = S_IDLE;
      endcase
      if (timeout_hit) begin
        state_d   = S_IDLE;
        auth_ok_d = 1'b0;
      end
    end
    txn_valid_d = (state_d == S_ISSUE);
    locked_d    = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pin_q       <= 4'd0;
      sel_q       <= 2'd0;
      amt_q       <= 4'd0;
      tries_q     <= 3'd0;
      txn_valid_q <= 1'b0;
      auth_ok_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_q       <= pin_d;
      sel_q       <= sel_d;
      amt_q       <= amt_d;
      tries_q     <= tries_d;
      txn_valid_q <= txn_valid_d;
      auth_ok_q   <= auth_ok_d;
      locked_q    <= locked_d;
    end
  end

  assign pin       = pin_q;
  assign sel       = sel_q;
  assign amt       = amt_q;
  assign tries     = tries_q;
  assign txn_valid = txn_valid_q;
  assign auth_ok   = auth_ok_q;
  assign locked    = locked_q;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Upstream session sequencer for the ATM `main` datapath. It collects keypad entries: a PIN, then a transaction select, then an amount.
- It authenticates the PIN against `prefed`, counts wrong attempts and locks after MAX_TRIES failures.
- It presents a validated {sel, amt} transaction to `main` with a valid/ready handshake.
- Its `pin`, `sel` and `amt` outputs drive the same-named `main` inputs.

Parameters:
- MAX_TRIES, 3, wrong-PIN attempts that force LOCK (range 1..7).
- TIMEOUT, 15, idle cycles without a key before the session aborts (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- card_in  in  1  level; high while a card is inserted.
- key_valid  in  1  single-cycle keypad strobe.
- key_data  in  4  keypad value, sampled when key_valid=1.
- prefed  in  4  stored PIN for the inserted card.
- txn_ready  in  1  downstream accepts the transaction.
- pin  out  4  last PIN entered.
- sel  out  2  transaction select (00 deposit, 01 withdraw).
- amt  out  4  transaction amount.
- txn_valid  out  1  transaction presented.
- auth_ok  out  1  PIN accepted for the current session.
- tries  out  3  consecutive wrong-PIN count.
- locked  out  1  high in LOCK.
- timeout  out  1  one-cycle pulse on session timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - pin, sel, amt and tries go to 0.
  - txn_valid, auth_ok, locked and timeout go to 0.
  - Idle counter goes to 0.
- All outputs are registered. State and outputs update on the clk edge that samples an input, so key-to-output latency is 1 cycle.
- States: IDLE, PIN, SEL, AMT, ISSUE, LOCK.
- IDLE: card_in=1 -> PIN. auth_ok=0. Keys are ignored.
- PIN, on key_valid:
  - pin <= key_data.
  - If key_data == prefed: -> SEL, auth_ok <= 1, tries <= 0.
  - Else tries <= tries+1. If tries+1 == MAX_TRIES, -> LOCK; otherwise stay in PIN.
- SEL, on key_valid:
  - If key_data[3:1] == 000: sel <= key_data[1:0], -> AMT.
  - Otherwise the key is ignored and the state stays SEL. Codes 10 and 11 are never produced.
- AMT, on key_valid: amt <= key_data, -> ISSUE. Value 0 is legal and passes through.
- ISSUE:
  - txn_valid=1; sel and amt are held stable.
  - On txn_valid & txn_ready: txn_valid <= 0, -> SEL for the next transaction. auth_ok stays 1.
  - Keys are ignored while in ISSUE.
- LOCK:
  - locked=1; all keys are ignored.
  - card_in does not exit LOCK. Only rst_n clears it.
  - tries holds MAX_TRIES.
- Card removal (card_in=0) in PIN, SEL, AMT or ISSUE:
  - -> IDLE on the next edge; txn_valid <= 0; auth_ok <= 0.
  - Removal has priority over a simultaneous key_valid or txn_ready; that key or handshake is discarded.
- tries persists across card removal. It clears only on a correct PIN or on reset.
- Idle counter:
  - Runs in PIN, SEL and AMT.
  - Clears on any key_valid, on any state change, and in every other state.
  - Saturates; it does not wrap.
- Simultaneous events: if key_valid arrives in the same cycle as the timeout condition, the key wins and the counter clears.
- pin, sel and amt keep their last values in IDLE. Downstream qualifies them with txn_valid.

Optional Feature:
- Macro: ATM_SESSION_TIMEOUT_EN.
- Defined: when the idle counter reaches TIMEOUT in PIN, SEL or AMT, the block pulses timeout=1 for one cycle, goes to IDLE and clears auth_ok. tries is unchanged.
- Not defined: no idle counter is built, timeout is tied 0, and a session ends only by card removal or reset.

Test Plan:
- prefed=0110, card_in=1, keys 0110, 0001, 0011, txn_ready=1 -> auth_ok=1; txn_valid pulses 1 cycle with sel=01, amt=0011; state returns to SEL.
- prefed=0110, keys 0011, 0011, 0011 -> tries=1, 2, 3; locked=1 one cycle after the third key; further keys and card_in toggles do not change outputs; rst_n=0 clears locked and tries.
- Keys 0011, then 0110 -> tries=1, then 0; auth_ok=1.
- In SEL, key 0101 -> ignored, state stays SEL; key 0000 -> sel=00, then AMT.
- In ISSUE with txn_ready=0 for 5 cycles -> txn_valid holds 1 and sel/amt stay stable; card_in=0 in the same cycle as txn_ready=1 -> IDLE, txn_valid=0, no transaction accepted.
- With ATM_SESSION_TIMEOUT_EN defined and TIMEOUT=15: no key for 15 cycles in AMT -> timeout pulses 1 cycle, state is IDLE, auth_ok=0; a key on cycle 14 -> no timeout.
